// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and types for the multi-port register file.
//   XLEN_DEF / NREG_DEF : default data width and register count.
//   reg_idx_t / xword_t : index and data word types at the default sizes.
//   REG_ZERO            : index of the hardwired-zero register.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  typedef logic [4:0]          reg_idx_t;
  typedef logic [XLEN_DEF-1:0] xword_t;

  localparam int unsigned REG_ZERO = 32'd0;

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: one busy bit per architectural register.
//   clk, reset           : core clock, synchronous active-high reset.
//   alloc_en, alloc_sel  : mark alloc_sel busy at the next edge.
//   wr_en, wr_sel, wr_clr: an enabled write with wr_clr retires busy[wr_sel].
//   busy                 : registered busy vector; bit 0 is always 0.
// An alloc and a clear to the same register in one cycle leave the bit set,
// since the alloc belongs to the younger producer.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREG = NREG_DEF,
  parameter  int NWR  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alloc_en,
  input  logic [AW-1:0]           alloc_sel,
  input  logic [NWR-1:0]          wr_en,
  input  logic [NWR-1:0][AW-1:0]  wr_sel,
  input  logic [NWR-1:0]          wr_clr,
  output logic [NREG-1:0]         busy
);

  localparam logic [NREG-1:0] ONE_HOT0  = {{(NREG-1){1'b0}}, 1'b1};
  localparam logic [NREG-1:0] KEEP_MASK = {{(NREG-1){1'b1}}, 1'b0};

  logic [NREG-1:0] busy_r;
  logic [NREG-1:0] clr_mask_s;
  logic [NREG-1:0] set_mask_s;
  logic [NREG-1:0] busy_nxt_s;

  // Next busy vector: clears applied first, then the alloc, so alloc wins a race.
  always_comb begin
    clr_mask_s = {NREG{1'b0}};
    for (int p = 0; p < NWR; p++) begin
      clr_mask_s = clr_mask_s | ({NREG{wr_en[p] & wr_clr[p]}} & (ONE_HOT0 << wr_sel[p]));
    end
    set_mask_s = {NREG{alloc_en}} & (ONE_HOT0 << alloc_sel);
    // Register 0 can never be busy.
    busy_nxt_s = ((busy_r & ~clr_mask_s) | set_mask_s) & KEEP_MASK;
  end

  // Busy state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= {NREG{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign busy = busy_r;

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: NRD-read / NWR-write integer register file with write-through
// bypass and a scoreboard of pending writes.
//   clk, reset                  : core clock, synchronous active-high reset.
//   rs_sel / rs_data / rs_busy  : per read port address, data and pending flag.
//   wr_en / wr_sel / wr_data    : per write port strobe, destination, data.
//   wr_clr                      : the write retires the busy mark of wr_sel.
//   alloc_en / alloc_sel        : mark a destination busy at issue.
// Higher write-port index wins both for storage and for the read bypass.
// Register 0 reads as zero and is never busy.
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN = XLEN_DEF,
  parameter  int NREG = NREG_DEF,
  parameter  int NRD  = 2,
  parameter  int NWR  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NRD-1:0][AW-1:0]  rs_sel,
  output logic [NRD-1:0][XLEN-1:0] rs_data,
  output logic [NRD-1:0]          rs_busy,
  input  logic [NWR-1:0]          wr_en,
  input  logic [NWR-1:0][AW-1:0]  wr_sel,
  input  logic [NWR-1:0][XLEN-1:0] wr_data,
  input  logic [NWR-1:0]          wr_clr,
  input  logic                    alloc_en,
  input  logic [AW-1:0]           alloc_sel
);

  localparam logic [AW-1:0] IDX_ZERO = AW'(REG_ZERO);

  logic [XLEN-1:0] regs_r [NREG];
  logic [NREG-1:0] busy_vec_s;

  rf_scoreboard #(
    .NREG (NREG),
    .NWR  (NWR)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .alloc_en  (alloc_en),
    .alloc_sel (alloc_sel),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_clr    (wr_clr),
    .busy      (busy_vec_s)
  );

  // Data array: ascending port loop so the highest-index port's write lands last.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && (wr_sel[p] != IDX_ZERO)) begin
          regs_r[wr_sel[p]] <= wr_data[p];
        end
      end
    end
  end

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    logic [XLEN-1:0] data_s;
    logic            busy_s;

    // Read port r: stored state, overridden by any same-cycle write to the same index.
    always_comb begin
      data_s = regs_r[rs_sel[r]];
      busy_s = busy_vec_s[rs_sel[r]];
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && (wr_sel[p] == rs_sel[r])) begin
          data_s = wr_data[p];
          // Any retiring write to this index makes it not-busy right away.
          busy_s = busy_s & ~wr_clr[p];
        end else begin
          data_s = data_s;
          busy_s = busy_s;
        end
      end
      if (rs_sel[r] == IDX_ZERO) begin
        data_s = {XLEN{1'b0}};
        busy_s = 1'b0;
      end else begin
        data_s = data_s;
        busy_s = busy_s;
      end
    end

    assign rs_data[r] = data_s;
    assign rs_busy[r] = busy_s;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed and randomized self-checking bench for reg_file_mp
// with NRD=3, NWR=2, XLEN=32, NREG=32.
module tb_reg_file_mp;

  localparam int NRD = 3;
  localparam int NWR = 2;

  logic                 clk;
  logic                 reset;
  logic [NRD-1:0][4:0]  rs_sel;
  logic [NRD-1:0][31:0] rs_data;
  logic [NRD-1:0]       rs_busy;
  logic [NWR-1:0]       wr_en;
  logic [NWR-1:0][4:0]  wr_sel;
  logic [NWR-1:0][31:0] wr_data;
  logic [NWR-1:0]       wr_clr;
  logic                 alloc_en;
  logic [4:0]           alloc_sel;

  int total;
  int bad;

  // Reference state: architectural registers and pending-write flags.
  logic [31:0] mreg  [32];
  bit          mbusy [32];

  reg_file_mp #(
    .XLEN (32),
    .NREG (32),
    .NRD  (NRD),
    .NWR  (NWR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rs_sel    (rs_sel),
    .rs_data   (rs_data),
    .rs_busy   (rs_busy),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .wr_clr    (wr_clr),
    .alloc_en  (alloc_en),
    .alloc_sel (alloc_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Expected read data: register 0 is zero; the last (highest) enabled writer to
  // the index is forwarded; otherwise the stored architectural value.
  function automatic logic [31:0] exp_data(input logic [4:0] s);
    logic [31:0] v;
    if (s == 5'd0) return 32'd0;
    v = mreg[s];
    for (int p = 0; p < NWR; p++)
      if (wr_en[p] && wr_sel[p] == s) v = wr_data[p];
    return v;
  endfunction

  // Expected busy: pending flag, dropped by any same-cycle retiring write.
  function automatic logic exp_busy(input logic [4:0] s);
    logic b;
    if (s == 5'd0) return 1'b0;
    b = mbusy[s];
    for (int p = 0; p < NWR; p++)
      if (wr_en[p] && wr_clr[p] && wr_sel[p] == s) b = 1'b0;
    return b;
  endfunction

  // Apply the current inputs to the reference state as a clock edge would.
  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mreg[i]  = 32'd0;
        mbusy[i] = 1'b0;
      end
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && wr_sel[p] != 5'd0) begin
          mreg[wr_sel[p]] = wr_data[p];
          if (wr_clr[p]) mbusy[wr_sel[p]] = 1'b0;
        end
      end
      if (alloc_en && alloc_sel != 5'd0) mbusy[alloc_sel] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr_en     = '0;
    wr_sel    = '0;
    wr_data   = '0;
    wr_clr    = '0;
    alloc_en  = 1'b0;
    alloc_sel = 5'd0;
  endtask

  task automatic check_port0(input string tag, input logic [31:0] d, input logic b);
    #1;
    check_val({tag, "_data"}, rs_data[0], d);
    check_val({tag, "_busy"}, {31'd0, rs_busy[0]}, {31'd0, b});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 32; i++) begin
      mreg[i]  = 32'd0;
      mbusy[i] = 1'b0;
    end
    idle();
    rs_sel = '0;
    reset  = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state on several addresses.
    rs_sel[0] = 5'd5; rs_sel[1] = 5'd31; rs_sel[2] = 5'd1;
    #1;
    for (int r = 0; r < NRD; r++) begin
      check_val("rst_data", rs_data[r], 32'd0);
      check_val("rst_busy", {31'd0, rs_busy[r]}, 32'd0);
    end

    // Write x5, confirm it, then reset must wipe it.
    wr_en[0] = 1'b1; wr_sel[0] = 5'd5; wr_data[0] = 32'hDEADBEEF;
    tick();
    idle();
    check_port0("x5_stored", 32'hDEADBEEF, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_port0("x5_after_rst", 32'd0, 1'b0);

    // Register 0: writes and allocs ignored.
    rs_sel[0] = 5'd0;
    wr_en[0] = 1'b1; wr_sel[0] = 5'd0; wr_data[0] = 32'h1234; wr_clr[0] = 1'b0;
    alloc_en = 1'b1; alloc_sel = 5'd0;
    check_port0("x0_same", 32'd0, 1'b0);
    tick();
    idle();
    check_port0("x0_next", 32'd0, 1'b0);

    // Collision and bypass on x7.
    rs_sel[0] = 5'd7;
    wr_en = 2'b11; wr_sel[0] = 5'd7; wr_sel[1] = 5'd7;
    wr_data[0] = 32'h11; wr_data[1] = 32'h22;
    check_port0("coll_bypass", 32'h22, 1'b0);
    tick();
    idle();
    check_port0("coll_stored", 32'h22, 1'b0);

    // Scoreboard on x9: same-cycle alloc is not yet visible.
    rs_sel[0] = 5'd9;
    alloc_en = 1'b1; alloc_sel = 5'd9;
    check_port0("alloc_same", 32'd0, 1'b0);
    tick();
    idle();
    tick(); tick(); tick();
    check_port0("alloc_busy", 32'd0, 1'b1);
    wr_en[0] = 1'b1; wr_sel[0] = 5'd9; wr_data[0] = 32'h55; wr_clr[0] = 1'b1;
    check_port0("clr_bypass", 32'h55, 1'b0);
    tick();
    idle();
    check_port0("clr_stored", 32'h55, 1'b0);

    // Write without clear leaves busy set.
    alloc_en = 1'b1; alloc_sel = 5'd12;
    tick();
    idle();
    rs_sel[0] = 5'd12;
    wr_en[1] = 1'b1; wr_sel[1] = 5'd12; wr_data[1] = 32'h77; wr_clr[1] = 1'b0;
    check_port0("noclr_same", 32'h77, 1'b1);
    tick();
    idle();
    check_port0("noclr_next", 32'h77, 1'b1);

    // Alloc/clear race on x3: alloc wins.
    rs_sel[0] = 5'd3;
    alloc_en = 1'b1; alloc_sel = 5'd3;
    tick();
    idle();
    check_port0("race_pre", 32'd0, 1'b1);
    alloc_en = 1'b1; alloc_sel = 5'd3;
    wr_en[0] = 1'b1; wr_sel[0] = 5'd3; wr_data[0] = 32'h33; wr_clr[0] = 1'b1;
    check_port0("race_same", 32'h33, 1'b0);
    tick();
    idle();
    check_port0("race_next", 32'h33, 1'b1);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 10000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      for (int r = 0; r < NRD; r++)
        rs_sel[r] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      for (int p = 0; p < NWR; p++) begin
        wr_en[p]   = ($urandom_range(0, 2) != 0);
        wr_sel[p]  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        wr_data[p] = $urandom;
        wr_clr[p]  = $urandom_range(0, 1) == 1;
      end
      alloc_en  = ($urandom_range(0, 1) == 1);
      alloc_sel = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      #1;
      for (int r = 0; r < NRD; r++) begin
        check_val("rnd_data", rs_data[r], exp_data(rs_sel[r]));
        check_val("rnd_busy", {31'd0, rs_busy[r]}, {31'd0, exp_busy(rs_sel[r])});
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
